sfx_sequencer: RTL and testbench
================================

Name: sfx_sequencer

Overview:
- Upstream feeder of the audio codec write path.
- Accepts one-cycle sound-effect requests (start, chomp, eatghost, death) and arbitrates them by priority.
- Walks the matching address region of the 8-bit sample ROM and converts each sample to 24-bit signed PCM.
- Presents samples on the codec write handshake at a rate set by a per-sample frame-repeat count; outputs silence when idle.

Parameters:
- ADDR_W, 16, ROM address width.
- REPEAT, 6, codec frames per ROM sample (48 kHz codec / 8 kHz samples).
- ROM_LAT, 1, ROM read latency in cycles (registered q).

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request: game-start jingle (single-cycle pulse).
- chomp  in  1  request: pellet chomp.
- eatghost  in  1  request: ghost eaten.
- death  in  1  request: pacman death.
- write_ready  in  1  codec output FIFO can accept a sample.
- rom_q  in  8  ROM data, unsigned, valid ROM_LAT cycles after rom_address.
- rom_address  out  ADDR_W  ROM read address.
- write  out  1  sample strobe to codec.
- writedata  out  24  signed PCM sample, same value for left and right.
- busy  out  1  a sound is playing.
- sound_id  out  3  current sound: 0 none, 1 start, 2 chomp, 3 eatghost, 4 death.

Behaviour:
- Reset (reset=0, async): state IDLE, rom_address=0, writedata=0, busy=0, sound_id=0, repeat counter=0, write=0.
- write = write_ready in every state, so silence keeps the codec fed. A frame is "accepted" on a cycle where write=1.
- Priority: death > start > eatghost > chomp. If several requests arrive in the same cycle, the highest wins.
- A request of strictly higher priority than the current sound preempts it on the next cycle.
- A request equal to the current sound restarts that sound from its first address.
- A lower-priority request is dropped, not queued.
- States:
  - IDLE: writedata=0.
  - On a winning request go to LOAD: rom_address=region start, busy=1, sound_id set.
  - LOAD waits ROM_LAT cycles, then latches the sample and goes to PLAY. writedata holds its prior value (0 from IDLE) during LOAD.
  - PLAY: writedata = {~rom_q[7], rom_q[6:0], 16'h0000}, i.e. (q-128)<<16, latched into a sample register.
  - Each accepted frame increments the repeat counter.
  - On the REPEAT-th accepted frame the counter clears. If rom_address == region end, go to IDLE (busy=0, sound_id=0, writedata=0 the next cycle). Otherwise rom_address+1 and go to LOAD.
- Every sample is presented for exactly REPEAT accepted frames. A region of N bytes therefore produces N*REPEAT frames.
- write_ready held low: the sequencer stalls. No address advance and no counter change.
- Preempt or restart mid-LOAD: the pending ROM data is discarded and the ROM_LAT wait restarts from the new address.
- Requests during reset are ignored.

Optional Feature:
- Macro: SFX_VOLUME_EN.
- Defined: adds input port volume (2 bits). writedata becomes the sample arithmetic-shifted right by volume (0 = full, 3 = ÷8). The shift is applied when the sample register is loaded; volume changes take effect at the next sample.
- Undefined: no volume port; full scale only.

Decomposition:
- Package sfx_pkg:
  - enum sound_t {SND_NONE, SND_START, SND_CHOMP, SND_EATGHOST, SND_DEATH}.
  - State enum.
  - Localparam arrays REGION_START / REGION_END indexed by sound_t (start 0–4095, chomp 4096–4607, eatghost 4608–5631, death 5632–8191).
  - function sound_prio(sound_t).
- One sub-module, sfx_arbiter: combinational priority select of the four requests, plus the preempt/restart decision against the current sound_id.

Test Plan:
- Reset, then write_ready pulsed every 8 cycles with no request → write follows write_ready, writedata=0, busy=0, sound_id=0.
- chomp pulse, ROM model with q=8'hFF at 4096 → rom_address=4096. After 1 cycle writedata=24'h7F0000 for 6 accepted frames, then rom_address=4097.
- chomp played to completion, region of 512 samples → exactly 3072 accepted frames, then busy=0, sound_id=0, writedata=0.
- chomp playing at 4200, death pulse → next cycle sound_id=4, rom_address=5632. Then a chomp pulse → ignored, death continues.
- start and chomp in the same cycle → sound_id=1, rom_address=0. A second start at address 100 → rom_address back to 0.
- Async reset asserted mid-PLAY between clock edges → outputs 0 immediately. With SFX_VOLUME_EN, volume=2 and q=8'h00 → writedata=24'hE00000.

Source files
------------

// File: rtl/sfx_pkg.sv
// rtl/sfx_pkg.sv - sound ids, sequencer states, ROM region map and priority ranking
package sfx_pkg;

  typedef enum logic [2:0] {
    SND_NONE     = 3'd0,
    SND_START    = 3'd1,
    SND_CHOMP    = 3'd2,
    SND_EATGHOST = 3'd3,
    SND_DEATH    = 3'd4
  } sound_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY
  } state_t;

  // Padded to eight entries so any 3-bit sound code indexes safely.
  localparam logic [31:0] REGION_START [0:7] = '{32'd0, 32'd0, 32'd4096, 32'd4608,
                                                 32'd5632, 32'd0, 32'd0, 32'd0};
  localparam logic [31:0] REGION_END   [0:7] = '{32'd0, 32'd4095, 32'd4607, 32'd5631,
                                                 32'd8191, 32'd0, 32'd0, 32'd0};

  function automatic logic [2:0] sound_prio(sound_t s);
    case (s)
      SND_DEATH:    return 3'd4;
      SND_START:    return 3'd3;
      SND_EATGHOST: return 3'd2;
      SND_CHOMP:    return 3'd1;
      default:      return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/sfx_arbiter.sv
// rtl/sfx_arbiter.sv - priority pick of the four requests and preempt/restart decision
module sfx_arbiter
  import sfx_pkg::*;
(
  input  logic       start,
  input  logic       chomp,
  input  logic       eatghost,
  input  logic       death,
  input  logic [2:0] current,
  output logic [2:0] win,
  output logic       take
);

  sound_t pick;

  always_comb begin
    pick = SND_NONE;
    if (death)         pick = SND_DEATH;
    else if (start)    pick = SND_START;
    else if (eatghost) pick = SND_EATGHOST;
    else if (chomp)    pick = SND_CHOMP;
  end

  assign win = pick;
  // Equal priority restarts the current sound; lower priority is dropped.
  assign take = (pick != SND_NONE) && (sound_prio(pick) >= sound_prio(sound_t'(current)));

endmodule

// File: rtl/sfx_sequencer.sv
// rtl/sfx_sequencer.sv - walks sample ROM regions and feeds 24-bit PCM to the codec
// Optional SFX_VOLUME_EN adds a 2-bit volume port (arithmetic right shift of each sample).
module sfx_sequencer
  import sfx_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int REPEAT  = 6,
  parameter int ROM_LAT = 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic              chomp,
  input  logic              eatghost,
  input  logic              death,
  input  logic              write_ready,
  input  logic [7:0]        rom_q,
`ifdef SFX_VOLUME_EN
  input  logic [1:0]        volume,
`endif
  output logic [ADDR_W-1:0] rom_address,
  output logic              write,
  output logic [23:0]       writedata,
  output logic              busy,
  output logic [2:0]        sound_id
);

  localparam int CNT_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam int LAT_W = (ROM_LAT > 0) ? $clog2(ROM_LAT + 1) : 1;

  state_t             state;
  logic [CNT_W-1:0]   rep_cnt;
  logic [LAT_W-1:0]   lat_cnt;
  logic [2:0]         win;
  logic               take;
  logic signed [23:0] pcm;
  logic [23:0]        sample;

  sfx_arbiter u_arbiter (
    .start    (start),
    .chomp    (chomp),
    .eatghost (eatghost),
    .death    (death),
    .current  (sound_id),
    .win      (win),
    .take     (take)
  );

  // Flipping the MSB turns unsigned offset-128 data into two's complement.
  assign pcm = {~rom_q[7], rom_q[6:0], 16'h0000};

`ifdef SFX_VOLUME_EN
  assign sample = pcm >>> volume;
`else
  assign sample = pcm;
`endif

  assign write = write_ready & reset;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      rom_address <= '0;
      writedata   <= '0;
      busy        <= 1'b0;
      sound_id    <= 3'd0;
      rep_cnt     <= '0;
      lat_cnt     <= '0;
    end else if (take) begin
      state       <= ST_LOAD;
      rom_address <= ADDR_W'(REGION_START[win]);
      busy        <= 1'b1;
      sound_id    <= win;
      rep_cnt     <= '0;
      lat_cnt     <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (lat_cnt == LAT_W'(ROM_LAT)) begin
            writedata <= sample;
            state     <= ST_PLAY;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        ST_PLAY: begin
          if (write_ready) begin
            if (rep_cnt == CNT_W'(REPEAT - 1)) begin
              rep_cnt <= '0;
              if (rom_address == ADDR_W'(REGION_END[sound_id])) begin
                state     <= ST_IDLE;
                busy      <= 1'b0;
                sound_id  <= 3'd0;
                writedata <= '0;
              end else begin
                rom_address <= rom_address + 1'b1;
                lat_cnt     <= '0;
                state       <= ST_LOAD;
              end
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sfx_sequencer.sv
// tb/tb_sfx_sequencer.sv - randomized self-checking bench for sfx_sequencer
module tb_sfx_sequencer;

  localparam int REPEAT = 6;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        chomp = 1'b0;
  logic        eatghost = 1'b0;
  logic        death = 1'b0;
  logic        write_ready = 1'b0;
  logic [7:0]  rom_q = 8'h00;
  logic [15:0] rom_address;
  logic        write;
  logic [23:0] writedata;
  logic        busy;
  logic [2:0]  sound_id;
`ifdef SFX_VOLUME_EN
  logic [1:0]  volume = 2'd0;
`endif

  logic [7:0] mem [0:8191];
  int         cnt [0:8191];
  int         vectors = 0;
  int         errors = 0;

  sfx_sequencer dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .start       (start),
    .chomp       (chomp),
    .eatghost    (eatghost),
    .death       (death),
    .write_ready (write_ready),
    .rom_q       (rom_q),
`ifdef SFX_VOLUME_EN
    .volume      (volume),
`endif
    .rom_address (rom_address),
    .write       (write),
    .writedata   (writedata),
    .busy        (busy),
    .sound_id    (sound_id)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) rom_q <= mem[rom_address[12:0]];

  function automatic logic [23:0] smp(input int a);
    int v;
    v = (int'(mem[a]) - 128) * 65536;
`ifdef SFX_VOLUME_EN
    v = v >>> volume;
`endif
    return v[23:0];
  endfunction

  function automatic int reg_start(input int id);
    case (id)
      1: return 0;
      2: return 4096;
      3: return 4608;
      4: return 5632;
      default: return 0;
    endcase
  endfunction

  function automatic int rank(input int id);
    case (id)
      4: return 4;
      1: return 3;
      3: return 2;
      2: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic init_rom();
    logic [7:0] v;
    for (int a = 0; a < 8192; a++) begin
      if (a == 4096) v = 8'hFF;
      else if (a == 4608) v = 8'h00;
      else begin
        v = 8'($urandom);
        while (v == 8'h00 || v == 8'h80 || v == 8'hFF || (a > 0 && v == mem[a-1]))
          v = 8'($urandom);
      end
      mem[a] = v;
    end
  endtask

  task automatic pulse(input logic s, input logic c, input logic e, input logic d);
    start = s; chomp = c; eatghost = e; death = d;
    @(negedge CLOCK_50);
    start = 1'b0; chomp = 1'b0; eatghost = 1'b0; death = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    write_ready = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    vectors++;
    if ({rom_address, writedata, busy, sound_id, write} !== 45'd0) begin
      errors++;
      $display("FAIL reset_outputs got addr=%0d data=%h busy=%b id=%0d write=%b want all 0",
               rom_address, writedata, busy, sound_id, write);
    end
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      write_ready = (i % 8 == 0);
      #2;
      vectors++;
      if ({write, writedata, busy, sound_id} !== {write_ready, 24'h0, 1'b0, 3'd0}) begin
        errors++;
        $display("FAIL idle_silence cyc=%0d got write=%b data=%h busy=%b id=%0d want write=%b data=0 busy=0 id=0",
                 i, write, writedata, busy, sound_id, write_ready);
      end
      @(negedge CLOCK_50);
    end
  endtask

  task automatic test_chomp_first();
    int n, k;
    write_ready = 1'b1;
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({rom_address, sound_id, busy} !== {16'd4096, 3'd2, 1'b1}) begin
      errors++;
      $display("FAIL chomp_start got addr=%0d id=%0d busy=%b want addr=4096 id=2 busy=1",
               rom_address, sound_id, busy);
    end
    n = 0; k = 0;
    while (rom_address == 16'd4096 && k < 40) begin
      if (write && writedata == 24'h7F0000) n++;
      @(negedge CLOCK_50); k++;
    end
    vectors++;
    if (n != REPEAT) begin
      errors++;
      $display("FAIL chomp_first_frames got %0d want %0d", n, REPEAT);
    end
    vectors++;
    if (rom_address !== 16'd4097) begin
      errors++;
      $display("FAIL chomp_advance got %0d want 4097", rom_address);
    end
    k = 0;
    while (writedata != smp(4097) && k < 10) begin
      @(negedge CLOCK_50); k++;
    end
    vectors++;
    if (writedata !== smp(4097)) begin
      errors++;
      $display("FAIL chomp_second_sample got %h want %h", writedata, smp(4097));
    end
  endtask

  task automatic test_chomp_full();
    int k, total, stray, bad;
    for (int a = 4096; a < 4608; a++) cnt[a] = 0;
    total = 0; stray = 0; bad = 0;
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (rom_address !== 16'd4096) begin
      errors++;
      $display("FAIL chomp_restart got %0d want 4096", rom_address);
    end
    k = 0;
    while (busy === 1'b1 && k < 20000) begin
      write_ready = ($urandom_range(0, 3) != 0);
      #2;
      if (write) begin
        if (rom_address < 16'd4096 || rom_address > 16'd4607) stray++;
        else if (writedata == smp(int'(rom_address))) begin
          cnt[rom_address]++;
          total++;
        end
      end
      @(negedge CLOCK_50); k++;
    end
    for (int a = 4096; a < 4608; a++) if (cnt[a] != REPEAT) bad++;
    vectors++;
    if (total != 512 * REPEAT) begin
      errors++;
      $display("FAIL chomp_total_frames got %0d want %0d", total, 512 * REPEAT);
    end
    vectors++;
    if (bad != 0 || stray != 0) begin
      errors++;
      $display("FAIL chomp_per_sample got bad=%0d stray=%0d want 0 0", bad, stray);
    end
    vectors++;
    if ({busy, sound_id, writedata} !== 28'd0) begin
      errors++;
      $display("FAIL chomp_end got busy=%b id=%0d data=%h want 0 0 0", busy, sound_id, writedata);
    end
  endtask

  task automatic test_preempt();
    int k;
    logic [23:0] held;
    write_ready = 1'b1;
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    k = 0;
    while (rom_address != 16'd4200 && k < 6000) begin
      @(negedge CLOCK_50); k++;
    end
    vectors++;
    if (rom_address !== 16'd4200) begin
      errors++;
      $display("FAIL reach_4200 got %0d want 4200", rom_address);
    end
    held = writedata;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if ({sound_id, rom_address, busy} !== {3'd4, 16'd5632, 1'b1}) begin
      errors++;
      $display("FAIL death_preempt got id=%0d addr=%0d busy=%b want id=4 addr=5632 busy=1",
               sound_id, rom_address, busy);
    end
    k = 0;
    while (writedata == held && k < 8) begin
      @(negedge CLOCK_50); k++;
    end
    vectors++;
    if (writedata !== smp(5632)) begin
      errors++;
      $display("FAIL death_first_sample got %h want %h", writedata, smp(5632));
    end
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (20) @(negedge CLOCK_50);
    vectors++;
    if (sound_id !== 3'd4 || rom_address < 16'd5632 || rom_address > 16'd5640) begin
      errors++;
      $display("FAIL chomp_dropped got id=%0d addr=%0d want id=4 addr in 5632..5640",
               sound_id, rom_address);
    end
  endtask

  task automatic test_async_reset();
    int k;
    k = 0;
    while (writedata != smp(int'(rom_address)) && k < 20) begin
      @(negedge CLOCK_50); k++;
    end
    @(posedge CLOCK_50);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({rom_address, writedata, busy, sound_id, write} !== 45'd0) begin
      errors++;
      $display("FAIL async_reset got addr=%0d data=%h busy=%b id=%0d write=%b want all 0",
               rom_address, writedata, busy, sound_id, write);
    end
    @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
  endtask

  task automatic test_simultaneous();
    int k;
    write_ready = 1'b1;
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({sound_id, rom_address} !== {3'd1, 16'd0}) begin
      errors++;
      $display("FAIL start_wins got id=%0d addr=%0d want id=1 addr=0", sound_id, rom_address);
    end
    k = 0;
    while (rom_address != 16'd100 && k < 2000) begin
      @(negedge CLOCK_50); k++;
    end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({sound_id, rom_address} !== {3'd1, 16'd0}) begin
      errors++;
      $display("FAIL start_restart got id=%0d addr=%0d want id=1 addr=0", sound_id, rom_address);
    end
    k = 0;
    while (writedata != smp(0) && k < 8) begin
      @(negedge CLOCK_50); k++;
    end
    vectors++;
    if (writedata !== smp(0)) begin
      errors++;
      $display("FAIL start_sample0 got %h want %h", writedata, smp(0));
    end
  endtask

  task automatic test_stall();
    int n, k;
    write_ready = 1'b0;
    repeat (30) @(negedge CLOCK_50);
    vectors++;
    if ({rom_address, writedata, write} !== {16'd0, smp(0), 1'b0}) begin
      errors++;
      $display("FAIL stall_hold got addr=%0d data=%h write=%b want addr=0 data=%h write=0",
               rom_address, writedata, write, smp(0));
    end
    write_ready = 1'b1;
    n = 0; k = 0;
    while (rom_address == 16'd0 && k < 40) begin
      #2;
      if (write && writedata == smp(0)) n++;
      @(negedge CLOCK_50); k++;
    end
    vectors++;
    if (n != REPEAT || rom_address !== 16'd1) begin
      errors++;
      $display("FAIL stall_resume got frames=%0d addr=%0d want frames=%0d addr=1", n, rom_address, REPEAT);
    end
  endtask

  task automatic test_random_requests();
    int cur, win, r;
    logic s, c, e, d, tk;
    reset = 1'b0;
    @(negedge CLOCK_50);
    reset = 1'b1;
    cur = 0;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 15);
      s = r[0]; c = r[1]; e = r[2]; d = r[3];
      win = d ? 4 : s ? 1 : e ? 3 : c ? 2 : 0;
      tk = (win != 0) && (rank(win) >= rank(cur));
      pulse(s, c, e, d);
      if (tk) begin
        cur = win;
        vectors++;
        if (int'(rom_address) != reg_start(cur)) begin
          errors++;
          $display("FAIL rand_addr iter=%0d got %0d want %0d", i, rom_address, reg_start(cur));
        end
      end
      vectors++;
      if (int'(sound_id) != cur || busy !== (cur != 0)) begin
        errors++;
        $display("FAIL rand_sound iter=%0d got id=%0d busy=%b want id=%0d busy=%b",
                 i, sound_id, busy, cur, cur != 0);
      end
      repeat ($urandom_range(0, 12)) begin
        write_ready = 1'($urandom_range(0, 1));
        @(negedge CLOCK_50);
      end
    end
  endtask

`ifdef SFX_VOLUME_EN
  task automatic test_volume();
    int k;
    reset = 1'b0;
    @(negedge CLOCK_50);
    reset = 1'b1;
    volume = 2'd2;
    write_ready = 1'b1;
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    k = 0;
    while (writedata == 24'h0 && k < 8) begin
      @(negedge CLOCK_50); k++;
    end
    vectors++;
    if (writedata !== 24'hE00000) begin
      errors++;
      $display("FAIL volume_shift got %h want e00000", writedata);
    end
    volume = 2'd0;
  endtask
`endif

  initial begin
    init_rom();
    test_reset();
    test_chomp_first();
    test_chomp_full();
    test_preempt();
    test_async_reset();
    test_simultaneous();
    test_stall();
    test_random_requests();
`ifdef SFX_VOLUME_EN
    test_volume();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
